// File: rtl/apb_timer_zcx.sv
// apb_timer_zcx: 32-bit prescaled down-counting APB timer with reload and IRQ.
// Build option APB_TIMER_SLVERR_EN: PSLVERR on unmapped/misaligned transfers.
module apb_timer_zcx #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32,
  parameter int PRESCW    = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 TIMER_IRQ
);

  logic [2:0]           ctrl_q, ctrl_d;
  logic [DATAWIDTH-1:0] load_q, load_d;
  logic [DATAWIDTH-1:0] value_q, value_d;
  logic [PRESCW-1:0]    presc_q, presc_d;
  logic [PRESCW-1:0]    pcnt_q, pcnt_d;
  logic                 ris_q, ris_d;
  logic [DATAWIDTH-1:0] prdata_q, prdata_d;
  logic                 rd_done_q, rd_done_d;

  logic [2:0]           widx;
  logic                 mapped;
  logic                 acc;
  logic                 wr_en;
  logic                 rd_cap;
  logic                 sel_ctrl, sel_load, sel_value;
  logic                 sel_presc, sel_int;
  logic                 wr_ctrl, wr_load, wr_value;
  logic                 wr_presc, wr_int;
  logic                 match;
  logic                 tick;
  logic                 expire;
  logic [DATAWIDTH-1:0] rmux;

  assign widx   = PADDR[4:2];
  assign mapped = (PADDR[ADDRWIDTH-1:5] == '0) &&
                  (PADDR[1:0] == 2'b00) &&
                  (widx <= 3'd4);

  assign acc    = PSEL & PENABLE;
  assign wr_en  = PCLKEN & acc & PWRITE & mapped;
  assign rd_cap = PCLKEN & acc & ~PWRITE & ~rd_done_q;

  assign sel_ctrl  = mapped & (widx == 3'd0);
  assign sel_load  = mapped & (widx == 3'd1);
  assign sel_value = mapped & (widx == 3'd2);
  assign sel_presc = mapped & (widx == 3'd3);
  assign sel_int   = mapped & (widx == 3'd4);

  assign wr_ctrl  = wr_en & sel_ctrl;
  assign wr_load  = wr_en & sel_load;
  assign wr_value = wr_en & sel_value;
  assign wr_presc = wr_en & sel_presc;
  assign wr_int   = wr_en & sel_int;

  // A VALUE write or a disabling CTRL write in the same cycle swallows the tick.
  assign match  = (pcnt_q == presc_q);
  assign tick   = PCLKEN & ctrl_q[0] & match & ~wr_value &
                  ~(wr_ctrl & ~PWDATA[0]);
  assign expire = tick & (value_q == '0);

  // Read-data mux over the register map; unmapped addresses read as zero.
  always_comb begin
    rmux = '0;
    unique case (1'b1)
      sel_ctrl:  rmux[2:0] = ctrl_q;
      sel_load:  rmux = load_q;
      sel_value: rmux = value_q;
      sel_presc: rmux[PRESCW-1:0] = presc_q;
      sel_int:   rmux[0] = ris_q;
      default:   rmux = '0;
    endcase
  end

  // Next-state for registers, counter, interrupt status and read handshake.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q + 1'b1;
    ris_d     = ris_q;
    prdata_d  = prdata_q;
    rd_done_d = 1'b0;

    if (wr_ctrl) begin
      ctrl_d = PWDATA[2:0];
    end else if (expire && ctrl_q[2]) begin
      ctrl_d[0] = 1'b0;
    end

    if (wr_load) begin
      load_d = PWDATA;
    end

    if (wr_presc) begin
      presc_d = PWDATA[PRESCW-1:0];
    end

    if (wr_value) begin
      value_d = PWDATA;
    end else if (tick) begin
      if (value_q != '0) begin
        value_d = value_q - 1'b1;
      end else if (!ctrl_q[2]) begin
        value_d = load_q;
      end
    end

    if (!ctrl_q[0] || wr_value || (wr_ctrl && PWDATA[0]) || match) begin
      pcnt_d = '0;
    end

    ris_d = (ris_q & ~(wr_int & PWDATA[0])) | expire;

    if (acc && !PWRITE) begin
      rd_done_d = ~rd_done_q;
    end

    if (rd_cap) begin
      prdata_d = rmux;
    end
  end

  // All state advances only on PCLKEN-qualified edges.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      value_q   <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      ris_q     <= 1'b0;
      prdata_q  <= '0;
      rd_done_q <= 1'b0;
    end else if (PCLKEN) begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      ris_q     <= ris_d;
      prdata_q  <= prdata_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = ~(acc & ~PWRITE & ~rd_done_q);
  assign TIMER_IRQ = ris_q & ctrl_q[1];

`ifdef APB_TIMER_SLVERR_EN
  assign PSLVERR = acc & PREADY & ~mapped;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: doc/apb_timer_zcx.md
# apb_timer_zcx

32-bit down-counting timer peripheral on the APB side of the AHB-to-APB bridge. It consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA from the bridge and returns PRDATA/PREADY/PSLVERR. Register access and timer ticks are qualified by the same PCLKEN the bridge uses. A prescaled tick decrements VALUE; the timer reloads from LOAD and raises an interrupt on expiry.

## Interface
- ADDRWIDTH, 16, APB address width; must match the bridge.
- DATAWIDTH, 32, APB data width; only 32 is supported.
- PRESCW, 8, prescaler width in bits.

- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- PCLKEN  in  1  APB clock enable; all APB and timer state advances only on HCLK edges with PCLKEN=1.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write.
- PADDR  in  ADDRWIDTH  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  registered read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error (see Configuration).
- TIMER_IRQ  out  1  RIS & IRQEN, level.

## Operation
Register map (word offsets):
- 0x00 CTRL, RW: bit0 EN, bit1 IRQEN, bit2 ONESHOT; other bits read 0.
- 0x04 LOAD, RW, 32 bits.
- 0x08 VALUE: read returns the count; a write loads the count directly.
- 0x0C PRESCALE, RW, [PRESCW-1:0]; a tick occurs every PRESCALE+1 PCLKEN cycles.
- 0x10 INTSTAT: bit0 RIS, write-1-to-clear.
- All registers reset to 0.

Counting, when EN=1:
- A prescaler counter increments on each PCLKEN cycle.
- When the counter equals PRESCALE, a tick occurs and the counter returns to 0.
- On a tick with VALUE!=0: VALUE <= VALUE-1.
- On a tick with VALUE==0: RIS <= 1.
  - Periodic mode: VALUE <= LOAD, so the period is LOAD+1 ticks.
  - ONESHOT=1: EN <= 0 and VALUE stays 0.
- LOAD=0 in periodic mode gives an interrupt every tick.

Counter control:
- The prescaler counter clears when EN=0, on any CTRL write that sets EN, and on any VALUE write.

Simultaneous events:
- A VALUE write and a tick in the same cycle: the write wins and no decrement occurs.
- A RIS set and a W1C clear in the same cycle: the set wins.
- A CTRL write of EN=0 in the tick cycle: the tick is ignored.

APB handshake, with rd_done as an internal flag:
- Writes: zero wait states. The register is written on the PCLKEN edge with PSEL&PENABLE&PWRITE. PREADY=1.
- Reads, first access cycle: rd_done=0, so PREADY=0. PRDATA is captured on that PCLKEN edge and rd_done is set.
- Reads, second access cycle: PREADY=1 and PRDATA is stable.
- rd_done clears on the completing edge.
- PREADY = ~(PSEL & PENABLE & ~PWRITE & ~rd_done).
- PRDATA holds its last value between reads.

Decode:
- Mapped means PADDR[ADDRWIDTH-1:5]==0, PADDR[1:0]==0, and offset <= 0x10.

## Timing
- Reset values: PRDATA=0, PREADY=1, PSLVERR=0, TIMER_IRQ=0, rd_done=0, all registers 0.
- Reset mid-transfer aborts the transfer. State is reset immediately (asynchronous); release is synchronous to HCLK.
- Write latency: the new register value is visible from the edge completing the access.
- Read latency: one setup PCLKEN cycle plus two access PCLKEN cycles.
- Read of VALUE returns the count as of the first access edge.
- RIS is set on the tick edge; TIMER_IRQ follows combinationally from RIS and IRQEN, with no extra cycle.
- PCLKEN=0 cycles: no state changes, and PREADY/PRDATA/PSLVERR hold.
- Wrap: VALUE never underflows; the transition 0 -> LOAD replaces the decrement.

## Configuration
- APB_TIMER_SLVERR_EN defined:
  - PSLVERR=1 together with PREADY=1 in the completing access cycle of any unmapped or misaligned transfer.
  - Writes to unmapped addresses are suppressed.
  - Unmapped reads return PRDATA=0.
  - Read wait-state behaviour is unchanged.
- Undefined: PSLVERR is tied 0, unmapped writes are silently ignored, and unmapped reads return 0.

## Test plan
- Reset, then read all five registers -> each returns 0x0; PSLVERR=0; TIMER_IRQ=0.
- Periodic mode: LOAD=3, PRESCALE=0, CTRL=0x3, PCLKEN=1 constantly -> TIMER_IRQ rises 1 cycle after EN write (VALUE was 0), then RIS re-set every 4 cycles; VALUE sequence 3,2,1,0,3.
- Prescaler with PCLKEN toggling every other cycle: PRESCALE=1 -> one tick every 4 HCLK cycles; VALUE write of 10 mid-count -> next read shows 10 and the prescaler restarts.
- One-shot: VALUE=2, CTRL=0x7 -> after 3 ticks RIS=1, CTRL reads 0x6, VALUE stays 0. Then write INTSTAT=1 in the same cycle as a fresh expiry -> RIS remains 1.
- Read handshake -> PREADY low for exactly one access cycle; PRDATA valid with PREADY=1; back-to-back write-then-read through the bridge at HCLK:PCLKEN=2:1 completes correctly.
- With APB_TIMER_SLVERR_EN: write 0xFFFF_FFFF to 0x14 -> PSLVERR=1 and no register changes; read 0x02 -> PSLVERR=1, PRDATA=0. Without the macro: PSLVERR stays 0 for the same stimulus.
